// File: rtl/sram_cfg_pkg.sv
// sram_cfg_pkg
//   Shared SRAM geometry defaults, the write-queue entry type, and a popcount
//   helper used by the write scheduler.
package sram_cfg_pkg;

    localparam int SRAM_INDEX_DEF = 5;
    localparam int SRAM_WIDTH_DEF = 32;

    typedef struct packed {
        logic [SRAM_INDEX_DEF-1:0] addr;
        logic [SRAM_WIDTH_DEF-1:0] data;
    } wrsched_entry_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/wrsched_compact.sv
// wrsched_compact
//   Prefix-sum compaction of the producer lanes. Each valid lane gets the slot
//   offset (relative to the queue tail) equal to the number of valid lanes
//   below it, so lane 0 is always the oldest.
// Ports
//   valid_i   in   IN_PORTS       per-lane request
//   offset_o  out  IN_PORTS*CW    lane k slot offset in [k*CW +: CW]
//   count_o   out  CW             number of valid lanes
module wrsched_compact
    import sram_cfg_pkg::*;
#(
    parameter int IN_PORTS = 4,
    parameter int CW       = $clog2(IN_PORTS + 1)
) (
    input  logic [IN_PORTS-1:0]    valid_i,
    output logic [IN_PORTS*CW-1:0] offset_o,
    output logic [CW-1:0]          count_o
);

    logic [CW-1:0] acc;

    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int k = 0; k < IN_PORTS; k++) begin
            offset_o[k*CW +: CW] = acc;
            acc = acc + CW'(valid_i[k]);
        end
    end

    assign count_o = CW'(popcount(32'(valid_i)));

endmodule

// File: rtl/sram_write_scheduler.sv
// sram_write_scheduler
//   Collects register writeback requests from IN_PORTS producer lanes into a
//   circular queue and drains up to WR_PORTS entries per cycle, oldest first,
//   onto the SRAM write ports. Oldest goes to port 0 so the SRAM's
//   highest-port-wins rule keeps program order for same-address writes.
// Configuration
//   WRSCHED_COMBINE_EN : within a drain group, an entry overwritten by a younger
//                        entry of the same group has its write enable cleared
//                        (still popped). SRAM contents are unchanged either way.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid_i/addr/data  producer lanes (lane k at [k*W +: W])
//   in_ready_o            all lanes accepted this cycle when high
//   stall_i               suppresses draining this cycle
//   we_o/addrwr_o/datawr_o SRAM write ports (combinational from queue state)
//   count_o, empty_o      registered occupancy
module sram_write_scheduler
    import sram_cfg_pkg::*;
#(
    parameter int SRAM_INDEX = SRAM_INDEX_DEF,
    parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
    parameter int IN_PORTS   = 4,
    parameter int WR_PORTS   = 6,
    parameter int QDEPTH     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [IN_PORTS-1:0]            in_valid_i,
    input  logic [IN_PORTS*SRAM_INDEX-1:0] in_addr_i,
    input  logic [IN_PORTS*SRAM_WIDTH-1:0] in_data_i,
    output logic                           in_ready_o,
    input  logic                           stall_i,
    output logic [WR_PORTS-1:0]            we_o,
    output logic [WR_PORTS*SRAM_INDEX-1:0] addrwr_o,
    output logic [WR_PORTS*SRAM_WIDTH-1:0] datawr_o,
    output logic [$clog2(QDEPTH+1)-1:0]    count_o,
    output logic                           empty_o
);

    localparam int PW     = $clog2(QDEPTH);
    localparam int CNTW   = $clog2(QDEPTH + 1);
    localparam int CW     = $clog2(IN_PORTS + 1);
    localparam int WR_CAP = (WR_PORTS < QDEPTH) ? WR_PORTS : QDEPTH;
    localparam logic [CNTW-1:0] RDY_MAX = CNTW'(QDEPTH - IN_PORTS);

    logic [SRAM_INDEX-1:0] addr_q [QDEPTH];
    logic [SRAM_WIDTH-1:0] data_q [QDEPTH];

    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CNTW-1:0]        count_q, count_d;
    logic [CNTW-1:0]        ndrain;
    logic [IN_PORTS*CW-1:0] lane_off;
    logic [CW-1:0]          lane_cnt;
    logic [CW-1:0]          acc_cnt;

    wrsched_compact #(
        .IN_PORTS (IN_PORTS),
        .CW       (CW)
    ) u_compact (
        .valid_i  (in_valid_i),
        .offset_o (lane_off),
        .count_o  (lane_cnt)
    );

    // Readiness depends only on registered occupancy, never on this cycle's drain.
    assign in_ready_o = (count_q <= RDY_MAX);
    assign acc_cnt    = in_ready_o ? lane_cnt : '0;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    // Reset suppresses the drain so no write escapes in the discarding cycle.
    always_comb begin
        ndrain = '0;
        if (!reset && !stall_i) begin
            ndrain = (count_q < CNTW'(WR_CAP)) ? count_q : CNTW'(WR_CAP);
        end
    end

    always_comb begin
        we_o     = '0;
        addrwr_o = '0;
        datawr_o = '0;
        for (int k = 0; k < WR_PORTS; k++) begin
            if (k < int'(ndrain)) begin
                we_o[k] = 1'b1;
                addrwr_o[k*SRAM_INDEX +: SRAM_INDEX] = addr_q[head_q + PW'(k)];
                datawr_o[k*SRAM_WIDTH +: SRAM_WIDTH] = data_q[head_q + PW'(k)];
`ifdef WRSCHED_COMBINE_EN
                for (int j = k + 1; j < WR_PORTS; j++) begin
                    if (j < int'(ndrain) &&
                        addr_q[head_q + PW'(j)] == addr_q[head_q + PW'(k)]) begin
                        we_o[k] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    always_comb begin
        head_d  = head_q + PW'(ndrain);
        tail_d  = tail_q + PW'(acc_cnt);
        count_d = count_q + CNTW'(acc_cnt) - ndrain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (!reset && in_ready_o) begin
            for (int k = 0; k < IN_PORTS; k++) begin
                if (in_valid_i[k]) begin
                    addr_q[tail_q + PW'(lane_off[k*CW +: CW])] <= in_addr_i[k*SRAM_INDEX +: SRAM_INDEX];
                    data_q[tail_q + PW'(lane_off[k*CW +: CW])] <= in_data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
                end
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q <= CNTW'(QDEPTH));

endmodule

// File: tb/tb_sram_write_scheduler.sv
module tb_sram_write_scheduler;
    import sram_cfg_pkg::*;

    localparam int AI = 5;
    localparam int DW = 32;
    localparam int IP = 4;
    localparam int WP = 6;
    localparam int QD = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [IP-1:0]     in_valid_i;
    logic [IP*AI-1:0]  in_addr_i;
    logic [IP*DW-1:0]  in_data_i;
    logic              in_ready_o;
    logic              stall_i;
    logic [WP-1:0]     we_o;
    logic [WP*AI-1:0]  addrwr_o;
    logic [WP*DW-1:0]  datawr_o;
    logic [4:0]        count_o;
    logic              empty_o;

    int n_chk  = 0;
    int n_pass = 0;

    wrsched_entry_t ref_q[$];
    logic [DW-1:0]  sram_m [32];

    sram_write_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid_i),
        .in_addr_i  (in_addr_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .stall_i    (stall_i),
        .we_o       (we_o),
        .addrwr_o   (addrwr_o),
        .datawr_o   (datawr_o),
        .count_o    (count_o),
        .empty_o    (empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Entered at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic [IP-1:0] v, input logic [IP*AI-1:0] a,
                         input logic [IP*DW-1:0] d, input logic st);
        int nd;
        logic [WP-1:0]    e_we;
        logic [WP*AI-1:0] e_a;
        logic [WP*DW-1:0] e_d;
        wrsched_entry_t   ent;
        in_valid_i = v;
        in_addr_i  = a;
        in_data_i  = d;
        stall_i    = st;
        #1;
        nd   = st ? 0 : ((ref_q.size() < WP) ? ref_q.size() : WP);
        e_we = '0;
        e_a  = '0;
        e_d  = '0;
        for (int k = 0; k < nd; k++) begin
            e_we[k] = 1'b1;
            e_a[k*AI +: AI] = ref_q[k].addr;
            e_d[k*DW +: DW] = ref_q[k].data;
        end
`ifdef WRSCHED_COMBINE_EN
        for (int k = 0; k < nd; k++)
            for (int j = k + 1; j < nd; j++)
                if (ref_q[j].addr == ref_q[k].addr) e_we[k] = 1'b0;
`endif
        chk("we",    we_o,       e_we);
        chk("addr",  addrwr_o,   e_a);
        chk("data",  datawr_o,   e_d);
        chk("count", count_o,    ref_q.size());
        chk("empty", empty_o,    ref_q.size() == 0);
        chk("ready", in_ready_o, (QD - ref_q.size()) >= IP);
        for (int k = 0; k < WP; k++)
            if (we_o[k]) sram_m[addrwr_o[k*AI +: AI]] = datawr_o[k*DW +: DW];
        if ((QD - ref_q.size()) >= IP) begin
            for (int k = 0; k < nd; k++) void'(ref_q.pop_front());
            for (int k = 0; k < IP; k++) begin
                if (v[k]) begin
                    ent.addr = a[k*AI +: AI];
                    ent.data = d[k*DW +: DW];
                    ref_q.push_back(ent);
                end
            end
        end else begin
            for (int k = 0; k < nd; k++) void'(ref_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st);
        cycle('0, '0, '0, st);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid_i = '0;
        stall_i    = 1'b0;
        #1;
        chk("rst_no_we", we_o, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ref_q.delete();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid_i = '0;
        in_addr_i  = '0;
        in_data_i  = '0;
        stall_i    = 1'b0;
        for (int i = 0; i < 32; i++) sram_m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("r_we",    we_o,       0);
        chk("r_addr",  addrwr_o,   0);
        chk("r_data",  datawr_o,   0);
        chk("r_count", count_o,    0);
        chk("r_ready", in_ready_o, 1);
        chk("r_empty", empty_o,    1);
        reset = 1'b0;

        // single write
        cycle(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {96'd0, 32'hDEADBEEF}, 1'b0);
        chk("t2_we",   we_o,          6'b000001);
        chk("t2_addr", addrwr_o[4:0], 5'd3);
        chk("t2_data", datawr_o[31:0], 32'hDEADBEEF);
        idle(1'b0);
        chk("t2_empty", empty_o, 1);

        // sparse lanes compact to ports 0/1
        cycle(4'b1010, {5'd7, 5'd0, 5'd5, 5'd0},
              {32'h77, 32'h0, 32'h55, 32'h0}, 1'b0);
        chk("t3_we",    we_o,          6'b000011);
        chk("t3_addr0", addrwr_o[4:0], 5'd5);
        chk("t3_addr1", addrwr_o[9:5], 5'd7);
        chk("t3_data1", datawr_o[63:32], 32'h77);
        idle(1'b0);

        // fill under stall to 13, backpressure, then drain across the wrap
        cycle(4'b0001, {4{5'd1}}, {4{32'h100}}, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(4'b1111, {5'd11, 5'd12, 5'd13, 5'd14},
                  {32'h200 + i * 4 + 3, 32'h200 + i * 4 + 2, 32'h200 + i * 4 + 1, 32'h200 + i * 4}, 1'b1);
        chk("t4_count13", count_o,    13);
        chk("t4_not_rdy", in_ready_o, 0);
        cycle(4'b1111, {4{5'd2}}, {4{32'hBAD}}, 1'b1);
        chk("t4_hold", count_o, 13);
        idle(1'b0);
        chk("t4_drain6", count_o, 7);
        idle(1'b0);
        idle(1'b0);
        chk("t4_empty", empty_o, 1);

        // same-cycle same-address ordering
        cycle(4'b0011, {5'd0, 5'd0, 5'd9, 5'd9}, {64'd0, 32'd2, 32'd1}, 1'b0);
`ifdef WRSCHED_COMBINE_EN
        chk("t5_we", we_o, 6'b000010);
`else
        chk("t5_we", we_o, 6'b000011);
`endif
        idle(1'b0);
        chk("t5_sram", sram_m[9], 32'd2);

        // accept 4 and drain 6 together at count 6
        cycle(4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1);
        cycle(4'b0011, {5'd0, 5'd0, 5'd6, 5'd5}, {64'd0, 32'h6, 32'h5}, 1'b1);
        chk("t6_count6", count_o, 6);
        cycle(4'b1111, {5'd10, 5'd9, 5'd8, 5'd7}, {32'hA, 32'h9, 32'h8, 32'h7}, 1'b0);
        chk("t6_count4", count_o, 4);
        idle(1'b0);

        // reset mid-burst at count 9
        cycle(4'b1111, {4{5'd20}}, {4{32'h20}}, 1'b1);
        cycle(4'b1111, {4{5'd21}}, {4{32'h21}}, 1'b1);
        cycle(4'b0001, {4{5'd22}}, {4{32'h22}}, 1'b1);
        chk("t1_count9", count_o, 9);
        do_reset();
        idle(1'b0);

        // random soak against the reference queue
        for (int i = 0; i < 300; i++) begin
            logic [IP*AI-1:0] ra;
            logic [IP*DW-1:0] rd;
            for (int k = 0; k < IP; k++) begin
                ra[k*AI +: AI] = AI'($urandom_range(0, 7));
                rd[k*DW +: DW] = $urandom;
            end
            cycle(IP'($urandom_range(0, 15)), ra, rd, $urandom_range(0, 3) == 0);
        end
        repeat (4) idle(1'b0);
        chk("soak_empty", empty_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
